dmem_arbiter: RTL

Arbitrates a single data-memory port between two requesters. The pipelined CPU's MEM stage is requester 0. A loader/debug master (bench preload, DMA, or debugger) is requester 1 and uses a valid/ready handshake. The block sits between the EX/MEM pipe register outputs and the data memory. When the CPU's access is not yet complete, it drives a stall that freezes the pipeline. It sequences a fixed-latency memory and prevents loader starvation.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage, loader and data-memory signals around dmem_arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/loader/memory view.
interface dmem_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic          cpu_req_i;
    logic          cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic [DW-1:0] cpu_rdata_o;
    logic          cpu_stall_o;

    logic          ldr_valid_i;
    logic          ldr_we_i;
    logic [AW-1:0] ldr_addr_i;
    logic [DW-1:0] ldr_wdata_i;
    logic          ldr_ready_o;
    logic          ldr_rvalid_o;
    logic [DW-1:0] ldr_rdata_o;

    logic          mem_read_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        input  ldr_valid_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
        output ldr_ready_o, ldr_rvalid_o, ldr_rdata_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        output ldr_valid_i, ldr_we_i, ldr_addr_i, ldr_wdata_i,
        input  ldr_ready_o, ldr_rvalid_o, ldr_rdata_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data-memory port between the CPU MEM stage and a
// valid/ready loader; CPU has priority, loader is forced in after STARVE_MAX CPU wins.
module dmem_arbiter #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_arbiter_if.slave    bus
);
    localparam int unsigned CW = $clog2(MEM_LAT) + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { GNT_CPU, GNT_LDR } gnt_t;

    state_t        state_q, state_d;
    gnt_t          gnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] starve_q, starve_d;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ldr_rdata_q;

    logic          grant_cpu;
    logic          grant_ldr;
    logic          busy;
    logic          done;
    logic          cpu_done;
    logic          ldr_done;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration is only evaluated in IDLE; requests seen during BUSY are ignored.
    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_ldr = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                grant_cpu = bus.cpu_req_i &&
                            !(bus.ldr_valid_i && (starve_q == STARVE_TOP));
                grant_ldr = bus.ldr_valid_i && !grant_cpu;
                if (grant_cpu || grant_ldr) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                done = (cnt_q == '0);
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant_ldr || !bus.ldr_valid_i) begin
                starve_d = '0;
            end else if (grant_cpu && (starve_q != STARVE_TOP)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    assign cpu_done = done && (gnt_q == GNT_CPU);
    assign ldr_done = done && (gnt_q == GNT_LDR);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            if (grant_cpu || grant_ldr) begin
                gnt_q   <= grant_ldr ? GNT_LDR : GNT_CPU;
                we_q    <= grant_ldr ? bus.ldr_we_i    : bus.cpu_we_i;
                addr_q  <= grant_ldr ? bus.ldr_addr_i  : bus.cpu_addr_i;
                wdata_q <= grant_ldr ? bus.ldr_wdata_i : bus.cpu_wdata_i;
                cnt_q   <= CNT_LOAD;
            end else if (busy && !done) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (cpu_done) begin
                cpu_rdata_q <= bus.mem_rdata_i;
            end
            if (ldr_done) begin
                ldr_rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    // Memory side is only driven while an access is in flight.
    assign bus.mem_read_o  = busy && !we_q;
    assign bus.mem_write_o = busy && we_q;
    assign bus.mem_addr_o  = busy ? addr_q  : '0;
    assign bus.mem_wdata_o = busy ? wdata_q : '0;

    // Read data bypasses the register in the completion cycle so MEM/WB captures it.
    assign bus.cpu_rdata_o  = cpu_done ? bus.mem_rdata_i : cpu_rdata_q;
    assign bus.cpu_stall_o  = rst_i && bus.cpu_req_i && !cpu_done;

    assign bus.ldr_ready_o  = rst_i && grant_ldr;
    assign bus.ldr_rvalid_o = ldr_done;
    assign bus.ldr_rdata_o  = ldr_done ? bus.mem_rdata_i : ldr_rdata_q;
endmodule
